// File: rtl/dual_issue_decoder_if.sv
// rtl/dual_issue_decoder_if.sv - fetch-side and register-read-side handshake bundle of the dual-issue decoder
`timescale 1ns/1ps

interface dual_issue_decoder_if #(
    parameter int IW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_ir0;
    logic [IW-1:0] in_ir1;
    logic [IW-1:0] in_pc;

    logic          out_valid0;
    logic          out_valid1;
    logic          out_ready;
    logic [2:0]    out_type0;
    logic [2:0]    out_type1;
    logic [IW-1:0] out_ir0;
    logic [IW-1:0] out_ir1;
    logic [IW-1:0] out_pc0;
    logic [IW-1:0] out_pc1;
    logic [4:0]    out_rs0;
    logic [4:0]    out_rs1;
    logic [4:0]    out_rt0;
    logic [4:0]    out_rt1;
    logic [4:0]    out_rd0;
    logic [4:0]    out_rd1;
    logic          out_we0;
    logic          out_we1;
    logic [IW-1:0] out_imm0;
    logic [IW-1:0] out_imm1;
    logic          out_illegal0;
    logic          out_illegal1;

    modport master (
        output in_valid, in_ir0, in_ir1, in_pc, out_ready,
        input  in_ready,
        input  out_valid0, out_valid1, out_type0, out_type1,
        input  out_ir0, out_ir1, out_pc0, out_pc1,
        input  out_rs0, out_rs1, out_rt0, out_rt1, out_rd0, out_rd1,
        input  out_we0, out_we1, out_imm0, out_imm1, out_illegal0, out_illegal1
    );

    modport slave (
        input  in_valid, in_ir0, in_ir1, in_pc, out_ready,
        output in_ready,
        output out_valid0, out_valid1, out_type0, out_type1,
        output out_ir0, out_ir1, out_pc0, out_pc1,
        output out_rs0, out_rs1, out_rt0, out_rt1, out_rd0, out_rd1,
        output out_we0, out_we1, out_imm0, out_imm1, out_illegal0, out_illegal1
    );
endinterface

// File: rtl/dual_issue_decoder.sv
// rtl/dual_issue_decoder.sv - 2-way decode/issue stage; lane pairing enabled by DUAL_ISSUE_EN
`timescale 1ns/1ps

module dual_issue_decoder (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    dual_issue_decoder_if.slave  bus
);

    typedef enum logic {
        S_PAIR = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    localparam logic [2:0] T_RR     = 3'b000;
    localparam logic [2:0] T_RI     = 3'b001;
    localparam logic [2:0] T_LOAD   = 3'b010;
    localparam logic [2:0] T_STORE  = 3'b011;
    localparam logic [2:0] T_BRANCH = 3'b100;
    localparam logic [2:0] T_JUMP   = 3'b101;
    localparam logic [2:0] T_NOP    = 3'b111;

    typedef struct packed {
        logic [2:0]  op_type;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } lane_t;

    localparam lane_t LANE_RST = '{op_type: T_NOP, ir: 32'd0, pc: 32'd0, imm: 32'd0,
                                   rs: 5'd0, rt: 5'd0, rd: 5'd0, we: 1'b0, illegal: 1'b0};

    // rd stays 0 for non-writing classes, so a non-zero rd alone implies a real write.
    function automatic lane_t decode(input logic [31:0] ir, input logic [31:0] pc);
        lane_t l;
        l.ir      = ir;
        l.pc      = pc;
        l.rs      = ir[25:21];
        l.rt      = ir[20:16];
        l.imm     = {{16{ir[15]}}, ir[15:0]};
        l.rd      = 5'd0;
        l.illegal = 1'b0;
        l.op_type = T_NOP;
        case (ir[31:26]) inside
            [6'd0:6'd7]: begin
                l.op_type = T_RR;
                l.rd      = ir[15:11];
            end
            [6'd8:6'd12]: begin
                l.op_type = T_RI;
                l.rd      = ir[20:16];
            end
            6'd16: begin
                l.op_type = T_LOAD;
                l.rd      = ir[20:16];
            end
            6'd17:         l.op_type = T_STORE;
            [6'd24:6'd27]: l.op_type = T_BRANCH;
            6'd32:         l.op_type = T_JUMP;
            6'd63:         l.op_type = T_NOP;
            default: begin
                l.op_type = T_NOP;
                l.illegal = 1'b1;
            end
        endcase
        l.we = (l.rd != 5'd0);
        return l;
    endfunction

    state_e      state_q, state_d;
    logic        out_valid0_q, out_valid0_d;
    lane_t       lane0_q, lane0_d;
    logic [31:0] held_ir_q, held_ir_d;
    logic [31:0] held_pc_q, held_pc_d;

    logic  in_ready_w;
    logic  advance;
    logic  accept;
    lane_t slot0;
    lane_t held_lane;

    // Decision is registered-state only, so in_valid never reaches in_ready.
    assign in_ready_w = (state_q == S_PAIR) & ~flush & ~rst & (~out_valid0_q | bus.out_ready);
    assign advance    = ~out_valid0_q | bus.out_ready;
    assign accept     = bus.in_valid & in_ready_w;
    assign slot0      = decode(bus.in_ir0, bus.in_pc);
    assign held_lane  = decode(held_ir_q, held_pc_q);

`ifdef DUAL_ISSUE_EN
    logic  out_valid1_q, out_valid1_d;
    lane_t lane1_q, lane1_d;
    lane_t slot1;
    logic  mem0, mem1;
    logic  split;

    assign slot1 = decode(bus.in_ir1, bus.in_pc + 32'd4);
    assign mem0  = (slot0.op_type == T_LOAD) | (slot0.op_type == T_STORE);
    assign mem1  = (slot1.op_type == T_LOAD) | (slot1.op_type == T_STORE);
    assign split = (slot0.we & ((slot1.rs == slot0.rd) | (slot1.rt == slot0.rd)))
                 | (slot0.we & slot1.we & (slot0.rd == slot1.rd))
                 | (mem0 & mem1)
                 | (slot0.op_type == T_BRANCH) | (slot0.op_type == T_JUMP);
`endif

    always_comb begin
        state_d      = state_q;
        out_valid0_d = out_valid0_q;
        lane0_d      = lane0_q;
        held_ir_d    = held_ir_q;
        held_pc_d    = held_pc_q;
`ifdef DUAL_ISSUE_EN
        out_valid1_d = out_valid1_q;
        lane1_d      = lane1_q;
`endif
        if (flush) begin
            out_valid0_d = 1'b0;
`ifdef DUAL_ISSUE_EN
            out_valid1_d = 1'b0;
`endif
            state_d      = S_PAIR;
        end else if (advance) begin
            case (state_q)
                S_PAIR: begin
                    if (accept) begin
                        out_valid0_d = 1'b1;
                        lane0_d      = slot0;
`ifdef DUAL_ISSUE_EN
                        if (split) begin
                            out_valid1_d = 1'b0;
                            lane1_d      = LANE_RST;
                            held_ir_d    = bus.in_ir1;
                            held_pc_d    = bus.in_pc + 32'd4;
                            state_d      = S_HOLD;
                        end else begin
                            out_valid1_d = 1'b1;
                            lane1_d      = slot1;
                        end
`else
                        held_ir_d    = bus.in_ir1;
                        held_pc_d    = bus.in_pc + 32'd4;
                        state_d      = S_HOLD;
`endif
                    end else begin
                        out_valid0_d = 1'b0;
`ifdef DUAL_ISSUE_EN
                        out_valid1_d = 1'b0;
`endif
                    end
                end
                S_HOLD: begin
                    // Younger slot of a split pair always goes out alone on lane 0.
                    out_valid0_d = 1'b1;
                    lane0_d      = held_lane;
`ifdef DUAL_ISSUE_EN
                    out_valid1_d = 1'b0;
                    lane1_d      = LANE_RST;
`endif
                    state_d      = S_PAIR;
                end
                default: state_d = S_PAIR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_PAIR;
            out_valid0_q <= 1'b0;
            lane0_q      <= LANE_RST;
            held_ir_q    <= 32'd0;
            held_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            out_valid0_q <= out_valid0_d;
            lane0_q      <= lane0_d;
            held_ir_q    <= held_ir_d;
            held_pc_q    <= held_pc_d;
        end
    end

`ifdef DUAL_ISSUE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid1_q <= 1'b0;
            lane1_q      <= LANE_RST;
        end else begin
            out_valid1_q <= out_valid1_d;
            lane1_q      <= lane1_d;
        end
    end

    assign bus.out_valid1   = out_valid1_q;
    assign bus.out_type1    = lane1_q.op_type;
    assign bus.out_ir1      = lane1_q.ir;
    assign bus.out_pc1      = lane1_q.pc;
    assign bus.out_rs1      = lane1_q.rs;
    assign bus.out_rt1      = lane1_q.rt;
    assign bus.out_rd1      = lane1_q.rd;
    assign bus.out_we1      = lane1_q.we;
    assign bus.out_imm1     = lane1_q.imm;
    assign bus.out_illegal1 = lane1_q.illegal;
`else
    assign bus.out_valid1   = 1'b0;
    assign bus.out_type1    = LANE_RST.op_type;
    assign bus.out_ir1      = LANE_RST.ir;
    assign bus.out_pc1      = LANE_RST.pc;
    assign bus.out_rs1      = LANE_RST.rs;
    assign bus.out_rt1      = LANE_RST.rt;
    assign bus.out_rd1      = LANE_RST.rd;
    assign bus.out_we1      = LANE_RST.we;
    assign bus.out_imm1     = LANE_RST.imm;
    assign bus.out_illegal1 = LANE_RST.illegal;
`endif

    assign bus.in_ready     = in_ready_w;
    assign bus.out_valid0   = out_valid0_q;
    assign bus.out_type0    = lane0_q.op_type;
    assign bus.out_ir0      = lane0_q.ir;
    assign bus.out_pc0      = lane0_q.pc;
    assign bus.out_rs0      = lane0_q.rs;
    assign bus.out_rt0      = lane0_q.rt;
    assign bus.out_rd0      = lane0_q.rd;
    assign bus.out_we0      = lane0_q.we;
    assign bus.out_imm0     = lane0_q.imm;
    assign bus.out_illegal0 = lane0_q.illegal;

endmodule

// File: tb/tb_dual_issue_decoder.sv
// tb/tb_dual_issue_decoder.sv - directed bench with issue-queue model for dual_issue_decoder
`timescale 1ns/1ps

module tb_dual_issue_decoder;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    dual_issue_decoder_if bus ();

    dual_issue_decoder dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          ty;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } slot_t;

    // Classify straight from the opcode table, then derive destination and write enable.
    function automatic slot_t dec(input logic [31:0] ir, input logic [31:0] pc);
        slot_t s;
        int op;
        op    = int'(ir[31:26]);
        s.ir  = ir;
        s.pc  = pc;
        s.rs  = ir[25:21];
        s.rt  = ir[20:16];
        s.imm = {{16{ir[15]}}, ir[15:0]};
        s.ill = 1'b0;
        if (op <= 7)                  s.ty = 0;
        else if (op >= 8 && op <= 12) s.ty = 1;
        else if (op == 16)            s.ty = 2;
        else if (op == 17)            s.ty = 3;
        else if (op >= 24 && op <= 27) s.ty = 4;
        else if (op == 32)            s.ty = 5;
        else if (op == 63)            s.ty = 7;
        else begin
            s.ty  = 7;
            s.ill = 1'b1;
        end
        if (s.ty == 0)                 s.rd = ir[15:11];
        else if (s.ty == 1 || s.ty == 2) s.rd = ir[20:16];
        else                           s.rd = 5'd0;
        s.we = (s.ty <= 2) && (s.rd != 5'd0);
        return s;
    endfunction

    function automatic bit can_pair(input slot_t a, input slot_t b);
`ifdef DUAL_ISSUE_EN
        bit raw, waw, mem2, ctl;
        raw  = a.we && (b.rs == a.rd || b.rt == a.rd);
        waw  = a.we && b.we && (a.rd == b.rd);
        mem2 = (a.ty == 2 || a.ty == 3) && (b.ty == 2 || b.ty == 3);
        ctl  = (a.ty == 4 || a.ty == 5);
        return !(raw || waw || mem2 || ctl);
`else
        return (a.ty < 0) && (b.ty < 0);
`endif
    endfunction

    bit    m_v0 = 1'b0;
    bit    m_v1 = 1'b0;
    bit    m_acc = 1'b0;
    slot_t m_l0;
    slot_t m_l1;
    slot_t m_pend[$];

    function automatic bit exp_ready();
        return !rst && !flush && (m_pend.size() == 0) && (!m_v0 || bus.out_ready);
    endfunction

    task automatic model_step();
        slot_t a, b;
        bit rdy;
        rdy   = exp_ready();
        m_acc = bus.in_valid && rdy;
        if (rst || flush) begin
            m_v0 = 1'b0;
            m_v1 = 1'b0;
            m_pend.delete();
        end else if (!m_v0 || bus.out_ready) begin
            if (m_pend.size() != 0) begin
                m_l0 = m_pend.pop_front();
                m_v0 = 1'b1;
                m_v1 = 1'b0;
            end else if (m_acc) begin
                a = dec(bus.in_ir0, bus.in_pc);
                b = dec(bus.in_ir1, bus.in_pc + 32'd4);
                m_l0 = a;
                m_v0 = 1'b1;
                if (can_pair(a, b)) begin
                    m_l1 = b;
                    m_v1 = 1'b1;
                end else begin
                    m_v1 = 1'b0;
                    m_pend.push_back(b);
                end
            end else begin
                m_v0 = 1'b0;
                m_v1 = 1'b0;
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
        chk("valid0", 32'(bus.out_valid0), 32'(m_v0));
        chk("valid1", 32'(bus.out_valid1), 32'(m_v1));
        if (m_v0) begin
            chk("l0_type", 32'(bus.out_type0), 32'(m_l0.ty));
            chk("l0_ir", bus.out_ir0, m_l0.ir);
            chk("l0_pc", bus.out_pc0, m_l0.pc);
            chk("l0_rs", 32'(bus.out_rs0), 32'(m_l0.rs));
            chk("l0_rt", 32'(bus.out_rt0), 32'(m_l0.rt));
            chk("l0_rd", 32'(bus.out_rd0), 32'(m_l0.rd));
            chk("l0_we", 32'(bus.out_we0), 32'(m_l0.we));
            chk("l0_imm", bus.out_imm0, m_l0.imm);
            chk("l0_ill", 32'(bus.out_illegal0), 32'(m_l0.ill));
        end
        if (m_v1) begin
            chk("l1_type", 32'(bus.out_type1), 32'(m_l1.ty));
            chk("l1_ir", bus.out_ir1, m_l1.ir);
            chk("l1_pc", bus.out_pc1, m_l1.pc);
            chk("l1_rs", 32'(bus.out_rs1), 32'(m_l1.rs));
            chk("l1_rt", 32'(bus.out_rt1), 32'(m_l1.rt));
            chk("l1_rd", 32'(bus.out_rd1), 32'(m_l1.rd));
            chk("l1_we", 32'(bus.out_we1), 32'(m_l1.we));
            chk("l1_imm", bus.out_imm1, m_l1.imm);
            chk("l1_ill", 32'(bus.out_illegal1), 32'(m_l1.ill));
        end
`ifndef DUAL_ISSUE_EN
        chk("l1_tied_type", 32'(bus.out_type1), 32'h7);
        chk("l1_tied_ir", bus.out_ir1, 32'h0);
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_ir0   = a;
        bus.in_ir1   = b;
        bus.in_pc    = pc;
    endtask

    localparam logic [31:0] ADD3   = 32'h00221800;
    localparam logic [31:0] ADDI4  = 32'h20240005;
    localparam logic [31:0] ADDI_R = 32'h20640005;
    localparam logic [31:0] LW5    = 32'h40250000;
    localparam logic [31:0] SW6    = 32'h4446FFFC;

    logic [31:0] tab0 [0:8];
    logic [31:0] tab1 [0:8];

    initial begin
        int idx;
        tab0[0] = ADD3;         tab1[0] = ADDI4;
        tab0[1] = ADD3;         tab1[1] = 32'h00851800;
        tab0[2] = 32'h60220010; tab1[2] = ADD3;
        tab0[3] = 32'h80000010; tab1[3] = ADDI4;
        tab0[4] = 32'h00220000; tab1[4] = 32'h20000007;
        tab0[5] = LW5;          tab1[5] = ADDI4;
        tab0[6] = SW6;          tab1[6] = LW5;
        tab0[7] = ADDI4;        tab1[7] = 32'h00821800;
        tab0[8] = ADD3;         tab1[8] = 32'h00432000;

        put(1'b0, 32'h0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_valid0", 32'(bus.out_valid0), 32'h0);
        chk("rst_valid1", 32'(bus.out_valid1), 32'h0);
        chk("rst_type0", 32'(bus.out_type0), 32'h7);
        chk("rst_type1", 32'(bus.out_type1), 32'h7);
        chk("rst_pc0", bus.out_pc0, 32'h0);
        chk("rst_imm0", bus.out_imm0, 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

        // independent pair
        put(1'b1, ADD3, ADDI4, 32'h100);
        cyc();
        bus.in_valid = 1'b0;
        chk("ind_valid0", 32'(bus.out_valid0), 32'h1);
        chk("ind_type0", 32'(bus.out_type0), 32'h0);
        chk("ind_rd0", 32'(bus.out_rd0), 32'h3);
        chk("ind_we0", 32'(bus.out_we0), 32'h1);
        chk("ind_pc0", bus.out_pc0, 32'h100);
`ifdef DUAL_ISSUE_EN
        chk("ind_valid1", 32'(bus.out_valid1), 32'h1);
        chk("ind_type1", 32'(bus.out_type1), 32'h1);
        chk("ind_rd1", 32'(bus.out_rd1), 32'h4);
        chk("ind_imm1", bus.out_imm1, 32'h5);
        chk("ind_pc1", bus.out_pc1, 32'h104);
        chk("ind_in_ready", 32'(bus.in_ready), 32'h1);
`else
        chk("ind_valid1", 32'(bus.out_valid1), 32'h0);
        chk("ind_in_ready", 32'(bus.in_ready), 32'h0);
        cyc();
        chk("ind2_type0", 32'(bus.out_type0), 32'h1);
        chk("ind2_rd0", 32'(bus.out_rd0), 32'h4);
        chk("ind2_imm0", bus.out_imm0, 32'h5);
        chk("ind2_pc0", bus.out_pc0, 32'h104);
`endif
        cyc();

        // RAW pair
        put(1'b1, ADD3, ADDI_R, 32'h200);
        cyc();
        bus.in_valid = 1'b0;
        chk("raw_valid0", 32'(bus.out_valid0), 32'h1);
        chk("raw_valid1", 32'(bus.out_valid1), 32'h0);
        chk("raw_type0", 32'(bus.out_type0), 32'h0);
        chk("raw_in_ready", 32'(bus.in_ready), 32'h0);
        cyc();
        chk("raw2_type0", 32'(bus.out_type0), 32'h1);
        chk("raw2_pc0", bus.out_pc0, 32'h204);
        chk("raw2_rs0", 32'(bus.out_rs0), 32'h3);
        cyc();

        // memory pair
        put(1'b1, LW5, SW6, 32'h300);
        cyc();
        bus.in_valid = 1'b0;
        chk("mem_type0", 32'(bus.out_type0), 32'h2);
        chk("mem_we0", 32'(bus.out_we0), 32'h1);
        chk("mem_rd0", 32'(bus.out_rd0), 32'h5);
        chk("mem_valid1", 32'(bus.out_valid1), 32'h0);
        chk("mem_in_ready", 32'(bus.in_ready), 32'h0);
        cyc();
        chk("mem2_type0", 32'(bus.out_type0), 32'h3);
        chk("mem2_imm0", bus.out_imm0, 32'hFFFFFFFC);
        chk("mem2_we0", 32'(bus.out_we0), 32'h0);
        chk("mem2_rd0", 32'(bus.out_rd0), 32'h0);
        chk("mem2_pc0", bus.out_pc0, 32'h304);
        cyc();

        // illegal opcode in slot 0
        put(1'b1, 32'hF8000000, 32'hFC000000, 32'h400);
        cyc();
        bus.in_valid = 1'b0;
        chk("ill_type0", 32'(bus.out_type0), 32'h7);
        chk("ill_flag0", 32'(bus.out_illegal0), 32'h1);
        chk("ill_we0", 32'(bus.out_we0), 32'h0);
`ifdef DUAL_ISSUE_EN
        chk("ill_valid1", 32'(bus.out_valid1), 32'h1);
        chk("ill_flag1", 32'(bus.out_illegal1), 32'h0);
`endif
        cyc();
        cyc();

        // backpressure, then flush while holding the younger slot
        bus.out_ready = 1'b0;
        put(1'b1, ADD3, ADDI_R, 32'h500);
        cyc();
        bus.in_valid = 1'b0;
        chk("bp_valid0", 32'(bus.out_valid0), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_pc0", bus.out_pc0, 32'h500);
            chk("bp_type0", 32'(bus.out_type0), 32'h0);
            chk("bp_valid0", 32'(bus.out_valid0), 32'h1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
        end
        flush = 1'b1;
        put(1'b1, ADD3, ADDI4, 32'h580);
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'h0);
        cyc();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_valid0", 32'(bus.out_valid0), 32'h0);
        chk("flush_valid1", 32'(bus.out_valid1), 32'h0);
        chk("flush_in_ready_after", 32'(bus.in_ready), 32'h1);
        cyc();
        chk("flush_dropped", 32'(bus.out_valid0), 32'h0);
        cyc();

        // reset while holding
        put(1'b1, ADD3, ADDI_R, 32'h600);
        cyc();
        bus.in_valid = 1'b0;
        chk("rh_valid0", 32'(bus.out_valid0), 32'h1);
        chk("rh_in_ready", 32'(bus.in_ready), 32'h0);
        rst = 1'b1;
        #1;
        chk("rh_in_ready_rst", 32'(bus.in_ready), 32'h0);
        cyc();
        rst = 1'b0;
        chk("rh_valid0_after", 32'(bus.out_valid0), 32'h0);
        chk("rh_valid1_after", 32'(bus.out_valid1), 32'h0);
        chk("rh_type0", 32'(bus.out_type0), 32'h7);
        chk("rh_type1", 32'(bus.out_type1), 32'h7);
        chk("rh_pc0", bus.out_pc0, 32'h0);
        chk("rh_rd0", 32'(bus.out_rd0), 32'h0);
        #1;
        chk("rh_in_ready_next", 32'(bus.in_ready), 32'h1);
        cyc();
        chk("rh_no_issue", 32'(bus.out_valid0), 32'h0);
        cyc();

        // streamed pairs with periodic backpressure, checked by the model
        idx = 0;
        for (int c = 0; c < 200 && idx < 9; c++) begin
            bus.out_ready = (c % 3) != 2;
            put(1'b1, tab0[idx], tab1[idx], 32'h1000 + 32'(idx) * 32'd8);
            cyc();
            if (m_acc) idx++;
        end
        chk("stream_done", 32'(idx), 32'd9);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_issue_decoder.md
# dual_issue_decoder

Front-end decode/issue stage of the 2-way superscalar core. It takes an aligned instruction pair from fetch and produces, per lane, the operation class, register specifiers, sign-extended immediate and PC that the lane ALUs consume. It detects intra-pair hazards and serialises a pair over two cycles when the lanes cannot issue together. Outputs are registered behind a valid/ready handshake toward register read.

## Interface
- `IW`, 32, instruction/PC/immediate width (fixed at 32).
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard pending/registered work (branch redirect).
- `in_valid`  in  1  fetch pair valid.
- `in_ready`  out  1  pair accepted when `in_valid & in_ready`.
- `in_ir0`, `in_ir1`  in  32 each  instructions, slot 0 older.
- `in_pc`  in  32  PC of slot 0; slot 1 PC = `in_pc + 4`.
- `out_valid0`, `out_valid1`  out  1 each  lane valid; `out_valid1` only with `out_valid0`.
- `out_ready`  in  1  downstream accepts both lanes together.
- `out_type0/1`  out  3 each  RR_ALU 000, RI_ALU 001, LOAD 010, STORE 011, BRANCH 100, JUMP 101, NOP 111.
- `out_ir0/1`, `out_pc0/1`  out  32 each  instruction and PC passthrough.
- `out_rs0/1`, `out_rt0/1`, `out_rd0/1`  out  5 each  IR[25:21], IR[20:16], destination.
- `out_we0/1`  out  1 each  register write enable.
- `out_imm0/1`  out  32 each  sign-extended IR[15:0].
- `out_illegal0/1`  out  1 each  opcode not in map.

## Operation
- Opcode IR[31:26] to class: 000000–000111 RR_ALU; 001000–001100 RI_ALU; 010000 LOAD; 010001 STORE; 011000–011011 BRANCH; 100000 JUMP; 111111 NOP; all others give NOP plus `illegal`.
- Destination: RR_ALU uses IR[15:11]; RI_ALU and LOAD use IR[20:16]; all other classes use rd=0, we=0. `we` is also 0 when the destination is r0.
- Pair split conditions, evaluated on the accepted pair:
  - RAW: `we0` and (rs1==rd0 or rt1==rd0).
  - WAW: `we0 & we1 & rd0==rd1`.
  - Both slots LOAD/STORE.
  - Slot 0 BRANCH or JUMP.
- FSM:
  - PAIR: no split gives both lanes valid. Split gives lane 0 = slot 0 only, slot 1 held internally, go to HOLD.
  - HOLD: `in_ready`=0. Next output slot issues held slot 1 on lane 0 with PC `in_pc+4`, `out_valid1`=0, then return to PAIR.
- `in_ready` = state==PAIR & !flush & (!out_valid0 | out_ready).
- Output registers update only when empty or `out_ready`=1. Otherwise they hold stable, with every field frozen while valid.
- `flush` has priority over everything. The next edge clears `out_valid0/1` and returns to PAIR. A pair presented during flush is not accepted.
- `rst` has the same effect as flush. Also on reset: all data outputs 0, `out_type0/1`=111, `in_ready` 0 during reset and 1 the cycle after.

## Timing
- Latency: accept edge to `out_valid0` = 1 cycle.
- Throughput: 1 pair/cycle unsplit; 2 cycles per split pair.
- Backpressure: with `out_ready`=0 and output full, `in_ready`=0. No combinational path from `in_valid` to `in_ready`.
- `out_ready` low in HOLD: held slot waits. `flush` during HOLD drops it.

## Configuration
- `DUAL_ISSUE_EN` defined: pairing per the rules above.
- Undefined: every pair takes the split path. `out_valid1` is constant 0. Lane-1 outputs are tied to their reset values.

## Test plan
- Independent pair: `in_ir0`=0x00221800 (ADD r3,r1,r2) and `in_ir1`=0x20240005 (ADDI r4,r1,5), pc=0x100 -> next cycle both lanes valid, types 000/001, rd 3/4, imm1=5, pc1=0x104.
- RAW: `in_ir1`=0x20640005 (ADDI r4,r3,5) -> cycle 1 lane 0 only (ADD). Cycle 2 lane 0 = ADDI with pc 0x104. `in_ready` low in cycle 1.
- Memory pair: 0x40250000 (LW r5,0(r1)) and 0x4446FFFC (SW r6,-4(r2)) -> split. LW we=1 rd=5. SW type 011, imm 0xFFFFFFFC, we=0.
- Illegal opcode: `in_ir0`=0xF8000000 -> type 111, `out_illegal0`=1, `we0`=0.
- Backpressure and flush: hold `out_ready`=0 for 3 cycles -> outputs stable, `in_ready`=0. Assert `flush` in HOLD -> next cycle `out_valid0`=0, state PAIR, held slot never issued.
- Reset mid-HOLD: `rst` 1 cycle -> all valids 0, types 111, `in_ready`=1 the following cycle.
